mul_div_unit: RTL

- Iterative RV32M/RV64M multiply/divide unit for the execute stage; generalises ALU decoding to `funct7 = 0000001` ops with multi-cycle execution.
- Decodes `funct3` into one of 8 M-extension ops and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Handshakes with the hazard unit: `ready_o`/`busy_o` stall the pipeline; `valid_o`/`ready_i` return the result to writeback.
- RISC-V divide special cases bypass iteration with 1-cycle latency.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_operand_prep.sv | 82 ++++++++
 rtl/mul_div_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
//   FUNCT7_MULDIV : funct7 value the main decoder uses to route ops here
//   mdu_op_t      : the eight funct3 M-extension operation codes
//   mdu_state_t   : sequencing states of the iterative unit
//   is_div_op     : true for DIV/DIVU/REM/REMU (funct3[2] set)
package mdu_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Combinational operand preparation for mul_div_unit.
// Decodes signedness from funct3, produces operand magnitudes, the sign to
// apply to the product/quotient and to the remainder, and detects the
// divide special cases (divide by zero, signed overflow) with their results.
//   funct3_i      : M-op select
//   src_a_i/b_i   : raw rs1/rs2 operands
//   mag_a_o/b_o   : magnitudes (raw value for unsigned operands)
//   neg_res_o     : product/quotient must be negated
//   neg_rem_o     : remainder must be negated (dividend was negative)
//   special_o     : op bypasses iteration
//   special_res_o : result to use when special_o is set
module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic [WIDTH-1:0] mag_a_o,
    output logic [WIDTH-1:0] mag_b_o,
    output logic             neg_res_o,
    output logic             neg_rem_o,
    output logic             special_o,
    output logic [WIDTH-1:0] special_res_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_a_signed;
    logic w_b_signed;
    logic w_a_neg;
    logic w_b_neg;
    logic w_b_zero;
    logic w_overflow;

    // Signedness decode per operation
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (mdu_op_t'(funct3_i))
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHSU: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
    end

    // Magnitudes, result signs and special-case detection
    always_comb begin
        w_a_neg    = w_a_signed & src_a_i[WIDTH-1];
        w_b_neg    = w_b_signed & src_b_i[WIDTH-1];
        // The most-negative value maps onto itself, which is its correct
        // unsigned magnitude.
        mag_a_o    = w_a_neg ? -src_a_i : src_a_i;
        mag_b_o    = w_b_neg ? -src_b_i : src_b_i;
        neg_res_o  = w_a_neg ^ w_b_neg;
        neg_rem_o  = w_a_neg;
        w_b_zero   = (src_b_i == ALL_ZERO);
        // Only DIV (100) and REM (110) can overflow
        w_overflow = funct3_i[2] & ~funct3_i[0] &
                     (src_a_i == MOST_NEG) & (src_b_i == ALL_ONES);
        special_o  = is_div_op(funct3_i) & (w_b_zero | w_overflow);
        if (w_b_zero) begin
            // funct3[1] selects remainder
            special_res_o = funct3_i[1] ? src_a_i : ALL_ONES;
        end else begin
            special_res_o = funct3_i[1] ? ALL_ZERO : src_a_i;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply or restoring divide, one step per cycle for
// WIDTH cycles; divide special cases finish in a single cycle.
//   clk, reset         : clock, synchronous active-high reset
//   flush_i            : abort any in-flight op, block acceptance
//   valid_i / ready_o  : op request handshake (ready only in IDLE)
//   funct3_i           : M-op select
//   src_a_i / src_b_i  : rs1 / rs2 operands
//   valid_o / ready_i  : result handshake toward writeback
//   result_o           : registered result, held after hand-off
//   busy_o             : high in CALC or DONE, drives the pipeline stall
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_neg_res;
    logic             r_neg_rem;
    // Multiply: r_hi/r_lo form the 2*WIDTH accumulator, r_lo shifting out
    // multiplier bits. Divide: r_hi is the partial remainder, r_lo shifts
    // the dividend out and the quotient in. r_opnd is multiplicand/divisor.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_res;
    logic               w_neg_rem;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_final;
    logic               w_accept;

    mdu_operand_prep #(
        .WIDTH (WIDTH)
    ) u_prep (
        .funct3_i      (funct3_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .mag_a_o       (w_mag_a),
        .mag_b_o       (w_mag_b),
        .neg_res_o     (w_neg_res),
        .neg_rem_o     (w_neg_rem),
        .special_o     (w_special),
        .special_res_o (w_special_res)
    );

    assign w_accept = valid_i & ~flush_i & (r_state == ST_IDLE);

    // One iteration step of the shift-add multiplier or restoring divider
    always_comb begin
        w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_opnd};
        if (is_div_op(r_op)) begin
            // Borrow out (bit WIDTH) means the trial subtraction failed: restore
            if (!w_diff[WIDTH]) begin
                w_next_hi = w_diff[WIDTH-1:0];
                w_next_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_next_hi = w_shift[WIDTH-1:0];
                w_next_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_next_hi = w_add[WIDTH:1];
            w_next_lo = {w_add[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and result selection on the final step's output
    always_comb begin
        w_prod_fix = r_neg_res ? -{w_next_hi, w_next_lo} : {w_next_hi, w_next_lo};
        w_quo_fix  = r_neg_res ? -w_next_lo : w_next_lo;
        w_rem_fix  = r_neg_rem ? -w_next_hi : w_next_hi;
        case (mdu_op_t'(r_op))
            OP_MUL:                      w_final = w_prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             w_final = w_quo_fix;
            OP_REM, OP_REMU:             w_final = w_rem_fix;
            default:                     w_final = {WIDTH{1'b0}};
        endcase
    end

    // Sequencing FSM, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_op      <= 3'b000;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_opnd    <= {WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_result  <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= funct3_i;
                        r_neg_res <= w_neg_res;
                        r_neg_rem <= w_neg_rem;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_hi    <= {WIDTH{1'b0}};
                            r_lo    <= w_mag_a;
                            r_opnd  <= w_mag_b;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_state <= ST_CALC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        r_valid <= 1'b0;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_IDLE;
                    end else begin
                        r_hi <= w_next_hi;
                        r_lo <= w_next_lo;
                        if (r_cnt == CNT_W'(1)) begin
                            r_result <= w_final;
                            r_valid  <= 1'b1;
                            r_cnt    <= {CNT_W{1'b0}};
                            r_state  <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (flush_i || ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == ST_IDLE);
    assign busy_o   = (r_state != ST_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule
